// File: rtl/or1200_wb_arb.sv
// Two-master (instruction/data) to one-slave Wishbone classic arbiter with
// round-robin tie break, whole-cycle bus ownership and a stall watchdog.
module or1200_wb_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            iwb_cyc_i,
    input  logic            iwb_stb_i,
    input  logic            iwb_we_i,
    input  logic [DW/8-1:0] iwb_sel_i,
    input  logic [AW-1:0]   iwb_adr_i,
    input  logic [DW-1:0]   iwb_dat_i,
    output logic [DW-1:0]   iwb_dat_o,
    output logic            iwb_ack_o,
    output logic            iwb_err_o,
    input  logic            dwb_cyc_i,
    input  logic            dwb_stb_i,
    input  logic            dwb_we_i,
    input  logic [DW/8-1:0] dwb_sel_i,
    input  logic [AW-1:0]   dwb_adr_i,
    input  logic [DW-1:0]   dwb_dat_i,
    output logic [DW-1:0]   dwb_dat_o,
    output logic            dwb_ack_o,
    output logic            dwb_err_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_I = 2'd1;
    localparam logic [1:0] OWN_D = 2'd2;

    localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT);

    logic [1:0]    state, state_nx;
    logic          last_d;
    logic [CW-1:0] wd_cnt, wd_cnt_nx;
    logic          own_i, own_d, own_cyc, own_stb, wd_fire;

    always_comb begin
        own_i   = (state == OWN_I);
        own_d   = (state == OWN_D);
        own_cyc = (own_i & iwb_cyc_i) | (own_d & dwb_cyc_i);
        own_stb = (own_i & iwb_cyc_i & iwb_stb_i) | (own_d & dwb_cyc_i & dwb_stb_i);
    end

    // A zero TIMEOUT removes the watchdog entirely.
    assign wd_fire = (TIMEOUT != 0) && own_stb && (wd_cnt == WD_LIMIT);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (iwb_cyc_i && dwb_cyc_i) state_nx = last_d ? OWN_I : OWN_D;
                else if (iwb_cyc_i)         state_nx = OWN_I;
                else if (dwb_cyc_i)         state_nx = OWN_D;
            end
            OWN_I:   if (!iwb_cyc_i) state_nx = dwb_cyc_i ? OWN_D : IDLE;
            OWN_D:   if (!dwb_cyc_i) state_nx = iwb_cyc_i ? OWN_I : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wd_cnt_nx = wd_cnt;
        if ((state_nx != state) || s_ack_i || s_err_i || wd_fire) wd_cnt_nx = '0;
        else if (own_stb)                                          wd_cnt_nx = wd_cnt + CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            last_d <= 1'b1;
            wd_cnt <= '0;
        end else begin
            state  <= state_nx;
            wd_cnt <= wd_cnt_nx;
            if (state_nx != state && state_nx == OWN_I) last_d <= 1'b0;
            if (state_nx != state && state_nx == OWN_D) last_d <= 1'b1;
        end
    end

    // Slave side is a pure mux of the registered owner; IDLE drives all zeros.
    always_comb begin
        s_cyc_o = own_cyc;
        s_stb_o = own_stb & ~wd_fire;
        s_we_o  = (own_i & iwb_we_i) | (own_d & dwb_we_i);
        s_sel_o = own_i ? iwb_sel_i : (own_d ? dwb_sel_i : '0);
        s_adr_o = own_i ? iwb_adr_i : (own_d ? dwb_adr_i : '0);
        s_dat_o = own_i ? iwb_dat_i : (own_d ? dwb_dat_i : '0);
    end

    // Responses are gated by the owner's cyc so a late ack after an abort is dropped.
    always_comb begin
        iwb_ack_o = own_i & iwb_cyc_i & s_ack_i;
        iwb_err_o = own_i & iwb_cyc_i & (s_err_i | wd_fire);
        dwb_ack_o = own_d & dwb_cyc_i & s_ack_i;
        dwb_err_o = own_d & dwb_cyc_i & (s_err_i | wd_fire);
        iwb_dat_o = s_dat_i;
        dwb_dat_o = s_dat_i;
    end

endmodule

// File: tb/tb_or1200_wb_arb.sv
// Scoreboard bench for or1200_wb_arb: a TIMEOUT=8 and a TIMEOUT=0 instance share
// stimulus; a transaction-level model predicts every cycle's outputs.
module tb_or1200_wb_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        icyc, istb, iwe, dcyc, dstb, dwe, sack, serr;
    logic [3:0]  isel, dsel;
    logic [31:0] iadr, idat, dadr, ddat, sdat;

    logic        a_iack, a_ierr, a_dack, a_derr, a_scyc, a_sstb, a_swe;
    logic [3:0]  a_ssel;
    logic [31:0] a_idat, a_ddat, a_sadr, a_sdat;
    logic        b_iack, b_ierr, b_dack, b_derr, b_scyc, b_sstb, b_swe;
    logic [3:0]  b_ssel;
    logic [31:0] b_idat, b_ddat, b_sadr, b_sdat;

    or1200_wb_arb #(.AW(32), .DW(32), .TIMEOUT(8), .CW(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .iwb_cyc_i(icyc), .iwb_stb_i(istb), .iwb_we_i(iwe), .iwb_sel_i(isel),
        .iwb_adr_i(iadr), .iwb_dat_i(idat), .iwb_dat_o(a_idat), .iwb_ack_o(a_iack), .iwb_err_o(a_ierr),
        .dwb_cyc_i(dcyc), .dwb_stb_i(dstb), .dwb_we_i(dwe), .dwb_sel_i(dsel),
        .dwb_adr_i(dadr), .dwb_dat_i(ddat), .dwb_dat_o(a_ddat), .dwb_ack_o(a_dack), .dwb_err_o(a_derr),
        .s_cyc_o(a_scyc), .s_stb_o(a_sstb), .s_we_o(a_swe), .s_sel_o(a_ssel),
        .s_adr_o(a_sadr), .s_dat_o(a_sdat), .s_dat_i(sdat), .s_ack_i(sack), .s_err_i(serr)
    );

    or1200_wb_arb #(.AW(32), .DW(32), .TIMEOUT(0), .CW(8)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n),
        .iwb_cyc_i(icyc), .iwb_stb_i(istb), .iwb_we_i(iwe), .iwb_sel_i(isel),
        .iwb_adr_i(iadr), .iwb_dat_i(idat), .iwb_dat_o(b_idat), .iwb_ack_o(b_iack), .iwb_err_o(b_ierr),
        .dwb_cyc_i(dcyc), .dwb_stb_i(dstb), .dwb_we_i(dwe), .dwb_sel_i(dsel),
        .dwb_adr_i(dadr), .dwb_dat_i(ddat), .dwb_dat_o(b_ddat), .dwb_ack_o(b_dack), .dwb_err_o(b_derr),
        .s_cyc_o(b_scyc), .s_stb_o(b_sstb), .s_we_o(b_swe), .s_sel_o(b_ssel),
        .s_adr_o(b_sadr), .s_dat_o(b_sdat), .s_dat_i(sdat), .s_ack_i(sack), .s_err_i(serr)
    );

    typedef struct packed {
        logic        s_cyc, s_stb, s_we;
        logic [3:0]  s_sel;
        logic [31:0] s_adr, s_dat;
        logic        ia, ie, da, de;
        logic [31:0] idat, ddat;
    } out_t;

    typedef struct packed {
        out_t e0, e1;
    } exp_t;

    exp_t q[$];
    out_t last_exp;
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;

    // Model: owner 0=none 1=I 2=D, last = most recently granted master.
    int T[2] = '{8, 0};
    int m_own[2], m_last[2], m_cnt[2];

    function automatic void mreset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = 0; m_last[k] = 2; m_cnt[k] = 0;
        end
    endfunction

    function automatic out_t mcomb(input int k, output logic fire);
        out_t o;
        logic ocyc, ostb;
        o = '0; ocyc = 1'b0; ostb = 1'b0;
        if (m_own[k] == 1) begin ocyc = icyc; ostb = istb; end
        else if (m_own[k] == 2) begin ocyc = dcyc; ostb = dstb; end
        fire = (T[k] != 0) && ocyc && ostb && (m_cnt[k] == T[k]);
        if (m_own[k] == 1) begin
            o.s_we = iwe; o.s_sel = isel; o.s_adr = iadr; o.s_dat = idat;
            o.ia = ocyc && sack; o.ie = ocyc && (serr || fire);
        end else if (m_own[k] == 2) begin
            o.s_we = dwe; o.s_sel = dsel; o.s_adr = dadr; o.s_dat = ddat;
            o.da = ocyc && sack; o.de = ocyc && (serr || fire);
        end
        o.s_cyc = ocyc;
        o.s_stb = ocyc && ostb && !fire;
        o.idat = sdat;
        o.ddat = sdat;
        return o;
    endfunction

    function automatic void madv(input int k);
        out_t o;
        logic fire;
        int   nxt, other, req_i, req_d;
        if (!rst_n) begin
            m_own[k] = 0; m_last[k] = 2; m_cnt[k] = 0;
            return;
        end
        o = mcomb(k, fire);
        req_i = int'(icyc); req_d = int'(dcyc);
        if (m_own[k] == 0) begin
            if (req_i != 0 && req_d != 0) nxt = (m_last[k] == 2) ? 1 : 2;
            else if (req_i != 0)          nxt = 1;
            else if (req_d != 0)          nxt = 2;
            else                          nxt = 0;
        end else if (o.s_cyc) begin
            nxt = m_own[k];
        end else begin
            other = 3 - m_own[k];
            nxt = ((other == 1 && req_i != 0) || (other == 2 && req_d != 0)) ? other : 0;
        end
        if (nxt != m_own[k] || sack || serr || fire) m_cnt[k] = 0;
        else if (o.s_stb)                            m_cnt[k] = m_cnt[k] + 1;
        if (nxt != 0 && nxt != m_own[k]) m_last[k] = nxt;
        m_own[k] = nxt;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        out_t a, b;
        cycle++;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {a_scyc, a_sstb, a_swe, a_ssel, a_sadr, a_sdat, a_iack, a_ierr, a_dack, a_derr, a_idat, a_ddat};
            b = {b_scyc, b_sstb, b_swe, b_ssel, b_sadr, b_sdat, b_iack, b_ierr, b_dack, b_derr, b_idat, b_ddat};
            checks++;
            if (a !== e.e0) begin
                failures++;
                $display("FAIL sb_to8 cycle=%0d got=%h expected=%h", cycle, a, e.e0);
            end
            checks++;
            if (b !== e.e1) begin
                failures++;
                $display("FAIL sb_to0 cycle=%0d got=%h expected=%h", cycle, b, e.e1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        madv(0);
        madv(1);
        #1;
    endtask

    task automatic push_exp();
        exp_t e;
        logic f;
        e.e0 = mcomb(0, f);
        e.e1 = mcomb(1, f);
        q.push_back(e);
        last_exp = e.e0;
    endtask

    task automatic nx();
        push_exp();
        #1;
    endtask

    task automatic idle_in();
        icyc = 0; istb = 0; iwe = 0; isel = 0; iadr = 0; idat = 0;
        dcyc = 0; dstb = 0; dwe = 0; dsel = 0; dadr = 0; ddat = 0;
        sack = 0; serr = 0; sdat = 0;
    endtask

    function automatic logic any_out();
        return |{a_scyc, a_sstb, a_swe, a_ssel, a_sadr, a_sdat, a_iack, a_ierr, a_dack, a_derr,
                 b_scyc, b_sstb, b_swe, b_ssel, b_sadr, b_sdat, b_iack, b_ierr, b_dack, b_derr};
    endfunction

    // Asserts reset between edges, checks outputs drop at once, then releases.
    task automatic do_reset();
        sack = 1;
        rst_n = 0;
        mreset();
        push_exp();
        #1;
        chk("rst_async_zero", any_out(), 0);
        sack = 0;
        tick(); push_exp();
        tick();
        rst_n = 1;
    endtask

    initial begin
        int stb_c, err_c, b_errs;
        bit ib, db, dead;
        idle_in();
        rst_n = 0;
        mreset();
        #1;
        chk("rst_init_zero", any_out(), 0);
        tick(); push_exp();
        tick(); rst_n = 1; nx();

        // I alone: one-cycle grant latency, ack routed to I only
        tick(); icyc = 1; istb = 1; iadr = 32'h100; nx();
        chk("t1_idle_no_cyc", a_scyc, 0);
        tick(); nx();
        chk("t1_grant_cyc", a_scyc, 1);
        chk("t1_grant_adr", a_sadr, 32'h100);
        tick(); nx();
        tick(); sack = 1; sdat = 32'hCAFE0001; nx();
        chk("t1_iack", a_iack, 1);
        chk("t1_dack", a_dack, 0);
        chk("t1_idat", a_idat, 32'hCAFE0001);
        tick(); sack = 0; icyc = 0; istb = 0; nx();
        tick(); nx();

        // First tie after reset goes to I; handover to D without idle cycle
        tick(); do_reset();
        icyc = 1; istb = 1; dcyc = 1; dstb = 1; iadr = 32'h200; dadr = 32'h300; nx();
        tick(); nx();
        chk("t2_tie_to_i", {a_scyc, a_sadr}, {1'b1, 32'h200});
        tick(); nx();
        tick(); nx();
        tick(); icyc = 0; istb = 0; nx();
        chk("t2_drop_same_cycle", {a_scyc, a_sstb}, 0);
        tick(); nx();
        chk("t2_handover_d", {a_scyc, a_sadr}, {1'b1, 32'h300});

        // Fairness: grant order I,D,I,D
        tick(); do_reset();
        iadr = 32'h1000; dadr = 32'h2000;
        icyc = 1; istb = 1; dcyc = 1; dstb = 1; nx();
        for (int n = 0; n < 4; n++) begin
            tick(); icyc = 1; istb = 1; dcyc = 1; dstb = 1; sack = 1; nx();
            chk($sformatf("t3_grant%0d", n), {a_scyc, a_sadr}, {1'b1, (n % 2 == 1) ? 32'h2000 : 32'h1000});
            tick(); sack = 0;
            if (n % 2 == 0) begin icyc = 0; istb = 0; end
            else begin dcyc = 0; dstb = 0; end
            nx();
        end
        tick(); idle_in(); nx();

        // Watchdog: err exactly 8 cycles after strobe reaches the slave
        tick(); do_reset();
        dcyc = 1; dstb = 1; dadr = 32'h400; nx();
        stb_c = -1; err_c = -1;
        for (int c = 1; c <= 20 && err_c < 0; c++) begin
            tick(); nx();
            if (a_sstb && stb_c < 0) stb_c = c;
            if (a_derr) begin
                err_c = c;
                chk("t4_stb_forced_low", a_sstb, 0);
                chk("t4_ierr_quiet", a_ierr, 0);
            end
        end
        chk("t4_wd_delay", 64'(err_c - stb_c), 64'(8));
        b_errs = 0;
        for (int c = 0; c < 1000; c++) begin
            tick(); nx();
            if (b_derr || b_ierr) b_errs++;
        end
        chk("t4_disabled_no_err", 64'(b_errs), 0);

        // Async reset mid-transfer, then D regranted one cycle after release
        tick(); do_reset();
        dadr = 32'h500; nx();
        chk("t5_not_yet", a_scyc, 0);
        tick(); nx();
        chk("t5_regrant", {a_scyc, a_sadr}, {1'b1, 32'h500});

        // Slave err to owner only; unowned ack in IDLE reaches nobody
        tick(); serr = 1; nx();
        chk("t6_derr", {a_derr, a_ierr, b_derr, b_ierr}, 4'b1010);
        tick(); serr = 0; dcyc = 0; dstb = 0; nx();
        tick(); nx();
        tick(); sack = 1; nx();
        chk("t6_unowned_ack", {a_iack, a_dack, b_iack, b_dack}, 0);
        tick(); sack = 0; nx();

        // Randomised traffic with stalls, aborts, stray responses and resets
        ib = 0; db = 0; dead = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            rst_n = 1;
            if ($urandom_range(49) == 0) dead = !dead;
            if (ib) begin
                if (last_exp.ia || last_exp.ie) begin
                    if ($urandom_range(1) == 0) ib = 0;
                    else begin iadr = $urandom; iwe = 1'($urandom); isel = 4'($urandom); idat = $urandom; end
                end else if ($urandom_range(49) == 0) ib = 0;
            end else if ($urandom_range(3) == 0) begin
                ib = 1; iadr = $urandom; iwe = 1'($urandom); isel = 4'($urandom); idat = $urandom;
            end
            if (db) begin
                if (last_exp.da || last_exp.de) begin
                    if ($urandom_range(1) == 0) db = 0;
                    else begin dadr = $urandom; dwe = 1'($urandom); dsel = 4'($urandom); ddat = $urandom; end
                end else if ($urandom_range(49) == 0) db = 0;
            end else if ($urandom_range(3) == 0) begin
                db = 1; dadr = $urandom; dwe = 1'($urandom); dsel = 4'($urandom); ddat = $urandom;
            end
            icyc = ib; istb = ib && ($urandom_range(9) != 0);
            dcyc = db; dstb = db && ($urandom_range(9) != 0);
            sack = !dead && ($urandom_range(2) == 0);
            serr = !dead && ($urandom_range(19) == 0);
            sdat = $urandom;
            if ($urandom_range(399) == 0) begin
                rst_n = 0;
                mreset();
                ib = 0; db = 0;
            end
            push_exp();
        end

        tick(); rst_n = 1; idle_in(); push_exp();
        tick(); push_exp();
        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
